// File: rtl/prio_enc_pipe.sv
// Three-stage pipelined priority encoder with valid/ready on both sides and a segmented two-level encode.
// Define PRIO_ONEHOT_EN to add the registered out_onehot output.
module prio_enc_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int IDX_W = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_found,
`ifdef PRIO_ONEHOT_EN
    output logic [WIDTH-1:0] out_onehot,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam int NSEG = WIDTH / SEG;
    localparam int LSW  = (SEG > 1) ? $clog2(SEG) : 1;

    logic             v0;
    logic [WIDTH-1:0] d0;
    logic             m0;
    logic [TAG_W-1:0] t0;

    logic             v1;
    logic             m1;
    logic [TAG_W-1:0] t1;
    logic             seg_found1 [NSEG];
    logic [LSW-1:0]   seg_idx1   [NSEG];

    logic             seg_found_c [NSEG];
    logic [LSW-1:0]   seg_idx_c   [NSEG];

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;

    logic load0;
    logic load1;
    logic load2;

    // A stage may advance when it is empty or its contents move on this cycle,
    // so in_ready depends combinationally on out_ready.
    assign load2    = !out_valid || out_ready;
    assign load1    = !v1 || load2;
    assign load0    = !v0 || load1;
    assign in_ready = load0;

    // Per-segment local winner; the scan order makes the last hit the winner.
    always_comb begin
        for (int s = 0; s < NSEG; s++) begin
            seg_found_c[s] = 1'b0;
            seg_idx_c[s]   = '0;
            for (int j = 0; j < SEG; j++) begin
                if (!m0) begin
                    if (d0[s*SEG + j]) begin
                        seg_found_c[s] = 1'b1;
                        seg_idx_c[s]   = LSW'(j);
                    end
                end else begin
                    if (d0[s*SEG + (SEG-1-j)]) begin
                        seg_found_c[s] = 1'b1;
                        seg_idx_c[s]   = LSW'(SEG-1-j);
                    end
                end
            end
        end
    end

    // Winning segment selection; the index is built arithmetically so upper bits stay zero.
    always_comb begin
        int win;
        sel_found = 1'b0;
        sel_idx   = '0;
        win       = 0;
        for (int s = 0; s < NSEG; s++) begin
            if (!m1) begin
                if (seg_found1[s]) begin
                    sel_found = 1'b1;
                    win       = s*SEG + int'(seg_idx1[s]);
                end
            end else begin
                if (seg_found1[NSEG-1-s]) begin
                    sel_found = 1'b1;
                    win       = (NSEG-1-s)*SEG + int'(seg_idx1[NSEG-1-s]);
                end
            end
        end
        if (sel_found) begin
            sel_idx = IDX_W'(win);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            d0 <= '0;
            m0 <= 1'b0;
            t0 <= '0;
        end else if (load0) begin
            v0 <= in_valid;
            if (in_valid) begin
                d0 <= in_data;
                m0 <= in_mode;
                t0 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            m1 <= 1'b0;
            t1 <= '0;
            for (int s = 0; s < NSEG; s++) begin
                seg_found1[s] <= 1'b0;
                seg_idx1[s]   <= '0;
            end
        end else if (load1) begin
            v1 <= v0;
            if (v0) begin
                m1 <= m0;
                t1 <= t0;
                for (int s = 0; s < NSEG; s++) begin
                    seg_found1[s] <= seg_found_c[s];
                    seg_idx1[s]   <= seg_idx_c[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_found  <= 1'b0;
            out_tag    <= '0;
`ifdef PRIO_ONEHOT_EN
            out_onehot <= '0;
`endif
        end else if (load2) begin
            out_valid <= v1;
            if (v1) begin
                out_idx    <= sel_idx;
                out_found  <= sel_found;
                out_tag    <= t1;
`ifdef PRIO_ONEHOT_EN
                out_onehot <= sel_found ? (WIDTH'(1) << sel_idx) : '0;
`endif
            end
        end
    end

endmodule

// File: doc/prio_enc_pipe.md
Name: prio_enc_pipe

Overview:
Parametrised, pipelined priority encoder with valid/ready handshake on both sides. It is the next generation of the single-register encoder used on the ring-oscillator capture vectors, and adds:
- selectable priority direction per transaction
- wide-vector support through a two-level segmented encode
- a sideband tag carried alongside each vector
- backpressure
It sits between the RO sample/capture logic and the downstream measurement/statistics path.

Parameters:
WIDTH, 16, input vector width; must be a multiple of SEG, >= 2
SEG, 4, segment width for the first-level encode; power of 2, <= WIDTH
IDX_W, 4, index width; must be >= ceil(log2(WIDTH))
TAG_W, 4, sideband tag width, passed through untouched

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector this cycle
in_data  in  WIDTH  vector to encode
in_mode  in  1  0 = highest set index wins, 1 = lowest set index wins
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_idx  out  IDX_W  winning bit index
out_found  out  1  at least one bit of the vector was set
out_tag  out  TAG_W  tag of the vector that produced this result

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk. Under reset:
  - all stage valid flags, out_valid, out_idx, out_found and out_tag are 0
  - in_ready is 1 from the first cycle after reset deasserts
- Stage S0, input register: captures in_data, in_mode and in_tag on the accept condition (in_valid && in_ready).
- Stage S1, segment encode:
  - WIDTH/SEG segments, each producing a local found flag and a local index of log2(SEG) bits
  - per segment, the local winner follows the S0 mode
  - mode and tag travel with the data
- Stage S2, output register:
  - selects the winning segment among those with local found = 1: highest segment for mode 0, lowest for mode 1
  - out_idx = {segment number, local index}, zero-extended to IDX_W
  - out_found = OR of all local found flags
  - out_found = 0 forces out_idx = 0
- Latency: a vector accepted in cycle t gives out_valid in cycle t+3 when no backpressure is applied.
- Throughput: 1 vector per cycle while out_ready = 1.
- Pipeline advance:
  - S2 loads when !out_valid || out_ready
  - S1 loads when S2 is empty or S2 loads
  - S0 loads when S1 is empty or S1 loads
  - a stage whose upstream holds no valid data loads a bubble (valid = 0)
  - bubbles collapse, so up to 3 vectors can be in flight
- in_ready = !v0 || S1 loads. This is a combinational path from out_ready; it is accepted and documented for integrators.
- Hold: while out_valid && !out_ready, out_idx, out_found and out_tag are held stable and no stage holding valid data advances.
- Simultaneous events: S2 may be consumed and reloaded in the same cycle. Accept and the S0-to-S1 transfer in the same cycle is legal.
- Data acceptance: in_data is ignored when in_valid = 0. in_valid asserted with in_ready = 0 has no effect; the upstream must hold its data.
- Reset mid-operation: all in-flight vectors are discarded with no output. out_valid is 0 in the cycle after rst_n is sampled low.
- Width rule: unused upper index bits, when IDX_W > ceil(log2(WIDTH)), are always 0.

Optional Feature:
- Macro: PRIO_ONEHOT_EN.
- Defined:
  - an extra output port out_onehot (WIDTH bits) is added, registered in S2
  - it has exactly one bit set, at position out_idx, when out_found = 1, and is all zeros otherwise
  - reset value 0; held with the other outputs under backpressure
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (defaults: WIDTH 16, SEG 4):
1. in_data=16'h0124, mode 0, tag 3, accepted at cycle t -> at t+3: out_valid=1, out_idx=8, out_found=1, out_tag=3. Same vector with mode 1 -> out_idx=2.
2. Boundary vectors:
   - 16'hFFFF -> idx 15 (mode 0), idx 0 (mode 1)
   - 16'h8000 -> idx 15 in both modes
   - 16'h0001 -> idx 0 in both modes
   - 16'h0000 -> out_found=0, out_idx=0
3. Five back-to-back vectors, out_ready held at 1 -> five results on five consecutive cycles, in order, tags 0..4, no bubbles.
4. out_ready=0 for 6 cycles while in_valid=1 -> in_ready drops after exactly 3 accepts; outputs stay stable. On release of out_ready -> results drain 1 per cycle, no loss or duplication.
5. Two vectors in flight, rst_n low for 1 cycle -> out_valid stays 0, neither result appears. A new vector afterwards -> correct result at +3 cycles.
6. PRIO_ONEHOT_EN defined, in_data=16'h0124, mode 0 -> out_onehot=16'h0100. Same vector, mode 1 -> 16'h0004. in_data=0 -> out_onehot=16'h0000.
